// File: rtl/npu_cmd_scheduler.sv
// In-order command executor between the SPI slave and the NPU tile datapath.
// Queues decoded frames, drives buffer/result/engine strobes, owns sticky err/ovf.
module npu_cmd_scheduler #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 4096,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_valid,
    input  logic [7:0] cmd,
    input  logic [2:0] tile_i,
    input  logic [2:0] tile_j,
    input  logic [2:0] op_code,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       buf_we,
    output logic [5:0] buf_addr,
    output logic [7:0] buf_wdata,
    output logic       res_re,
    output logic [5:0] res_addr,
    input  logic [7:0] res_rdata,
    output logic       eng_start,
    output logic [5:0] eng_tile,
    output logic [2:0] eng_op,
    input  logic       eng_done,
    output logic       busy,
    output logic       err,
    output logic       ovf
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int TMR_W = $clog2(TIMEOUT) + 1;
    localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    localparam logic [7:0] CMD_NOP    = 8'h00;
    localparam logic [7:0] CMD_WRITE  = 8'h01;
    localparam logic [7:0] CMD_READ   = 8'h02;
    localparam logic [7:0] CMD_START  = 8'h03;
    localparam logic [7:0] CMD_STATUS = 8'h04;

    typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_READ_WAIT, S_WAIT_DONE} state_t;

    typedef struct packed {
        logic [7:0] cmd;
        logic [2:0] ti;
        logic [2:0] tj;
        logic [2:0] op;
        logic [7:0] data;
    } entry_t;

    entry_t           fifo_mem [FIFO_DEPTH];
    entry_t           head;
    entry_t           wr_entry;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;
    logic             pop;
    logic             push;

    state_t           state_q;
    entry_t           cur_q;
    logic             rd_wait_q;
    logic [TMR_W-1:0] timer_q;
    logic [CNT_W-1:0] done_cnt_q;
    logic [3:0]       cnt_nib;

    // A full queue still accepts a frame when the head leaves on the same edge.
    assign pop      = (state_q == S_IDLE) && (count_q != '0);
    assign push     = frame_valid && ((count_q < DEPTH_C) || pop);
    assign head     = fifo_mem[rd_ptr_q];
    assign wr_entry = {cmd, tile_i, tile_j, op_code, data_in};
    assign busy     = (state_q != S_IDLE) || (count_q != '0);

    generate
        if (CNT_W >= 4) begin : g_cnt_trunc
            assign cnt_nib = done_cnt_q[3:0];
        end else begin : g_cnt_pad
            assign cnt_nib = {{(4 - CNT_W){1'b0}}, done_cnt_q};
        end
    endgenerate

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            fifo_mem[wr_ptr_q] <= wr_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cur_q      <= '0;
            rd_wait_q  <= 1'b0;
            timer_q    <= '0;
            done_cnt_q <= '0;
            data_out   <= '0;
            buf_we     <= 1'b0;
            buf_addr   <= '0;
            buf_wdata  <= '0;
            res_re     <= 1'b0;
            res_addr   <= '0;
            eng_start  <= 1'b0;
            eng_tile   <= '0;
            eng_op     <= '0;
            err        <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            buf_we    <= 1'b0;
            res_re    <= 1'b0;
            eng_start <= 1'b0;
            if (frame_valid && !push) ovf <= 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        cur_q   <= head;
                        state_q <= S_DISPATCH;
                    end
                end
                S_DISPATCH: begin
                    state_q <= S_IDLE;
                    case (cur_q.cmd)
                        CMD_NOP: ;
                        CMD_WRITE: begin
                            buf_we    <= 1'b1;
                            buf_addr  <= {cur_q.ti, cur_q.tj};
                            buf_wdata <= cur_q.data;
                        end
                        CMD_READ: begin
                            res_re    <= 1'b1;
                            res_addr  <= {cur_q.ti, cur_q.tj};
                            rd_wait_q <= 1'b0;
                            state_q   <= S_READ_WAIT;
                        end
                        CMD_START: begin
                            eng_start <= 1'b1;
                            eng_tile  <= {cur_q.ti, cur_q.tj};
                            eng_op    <= cur_q.op;
                            timer_q   <= '0;
                            state_q   <= S_WAIT_DONE;
                        end
                        CMD_STATUS: data_out <= {1'b0, ovf, err, 1'b0, cnt_nib};
                        default:    err <= 1'b1;
                    endcase
                end
                // The result RAM answers one cycle after res_re, so skip one cycle first.
                S_READ_WAIT: begin
                    if (rd_wait_q) begin
                        data_out <= res_rdata;
                        state_q  <= S_IDLE;
                    end else begin
                        rd_wait_q <= 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (eng_done) begin
                        done_cnt_q <= done_cnt_q + 1'b1;
                        state_q    <= S_IDLE;
                    end else if (timer_q == TMR_LAST) begin
                        err     <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_npu_cmd_scheduler.sv
// Scoreboard bench for npu_cmd_scheduler: a cycle-cost reference model predicts
// strobes and status; a negedge monitor pops and compares what the DUT presents.
module tb_npu_cmd_scheduler;
    localparam int DEPTH = 4;
    localparam int TMO   = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_valid = 1'b0;
    logic [7:0] cmd = '0;
    logic [2:0] tile_i = '0;
    logic [2:0] tile_j = '0;
    logic [2:0] op_code = '0;
    logic [7:0] data_in = '0;
    logic [7:0] data_out;
    logic       buf_we;
    logic [5:0] buf_addr;
    logic [7:0] buf_wdata;
    logic       res_re;
    logic [5:0] res_addr;
    logic [7:0] res_rdata = '0;
    logic       eng_start;
    logic [5:0] eng_tile;
    logic [2:0] eng_op;
    logic       eng_done = 1'b0;
    logic       busy;
    logic       err;
    logic       ovf;

    always #5 clk = ~clk;

    npu_cmd_scheduler #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .frame_valid(frame_valid), .cmd(cmd),
        .tile_i(tile_i), .tile_j(tile_j), .op_code(op_code), .data_in(data_in),
        .data_out(data_out), .buf_we(buf_we), .buf_addr(buf_addr), .buf_wdata(buf_wdata),
        .res_re(res_re), .res_addr(res_addr), .res_rdata(res_rdata),
        .eng_start(eng_start), .eng_tile(eng_tile), .eng_op(eng_op), .eng_done(eng_done),
        .busy(busy), .err(err), .ovf(ovf)
    );

    // Result RAM: fixed contents, registered read.
    logic [7:0] mem [64];
    always @(posedge clk) if (res_re) res_rdata <= mem[res_addr];

    typedef struct {
        logic [7:0] cmd;
        logic [2:0] ti;
        logic [2:0] tj;
        logic [2:0] op;
        logic [7:0] data;
        int         lat;
    } frame_t;

    typedef struct {
        int         cyc;
        logic [7:0] a;
        logic [7:0] b;
    } exp_t;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int stim_lat = 0;

    frame_t     mq[$];
    frame_t     cur;
    exp_t       wr_q[$];
    exp_t       rd_q[$];
    exp_t       st_q[$];
    int         drv_lat_q[$];
    int         disp_at = -1;
    int         cap_at = -1;
    int         fin_at = -1;
    int         next_pop = 0;
    bit         fin_done = 0;
    logic [7:0] cap_val = '0;
    logic       m_err = 1'b0;
    logic       m_ovf = 1'b0;
    logic [3:0] m_cnt = '0;
    logic [7:0] m_dout = '0;
    bit         m_valid = 0;
    bit         m_in_reset = 0;
    int         done_due = -1;
    bit         manual_done = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Each command occupies the scheduler for a fixed number of cycles after it
    // leaves the queue (engine launches: until done or timeout); effects land
    // at known offsets from the pop.
    task automatic model_edge();
        logic [7:0] st;
        bit set_err, set_ovf, inc, do_pop;
        int sz, m;
        frame_t f;
        if (rst_n !== 1'b1) begin
            mq.delete(); wr_q.delete(); rd_q.delete(); st_q.delete(); drv_lat_q.delete();
            disp_at = -1; cap_at = -1; fin_at = -1; next_pop = cyc + 1;
            m_err = 1'b0; m_ovf = 1'b0; m_cnt = '0; m_dout = '0;
            m_valid = 1; m_in_reset = 1;
            return;
        end
        m_in_reset = 0;
        if (!m_valid) return;
        st = {1'b0, m_ovf, m_err, 1'b0, m_cnt};
        set_err = 0; set_ovf = 0; inc = 0;
        if (disp_at == cyc) begin
            case (cur.cmd)
                8'h00: ;
                8'h01: wr_q.push_back('{cyc, {2'b00, cur.ti, cur.tj}, cur.data});
                8'h02: begin
                    rd_q.push_back('{cyc, {2'b00, cur.ti, cur.tj}, 8'h00});
                    cap_at  = cyc + 2;
                    cap_val = mem[{cur.ti, cur.tj}];
                end
                8'h03: st_q.push_back('{cyc, {2'b00, cur.ti, cur.tj}, {5'b00000, cur.op}});
                8'h04: m_dout = st;
                default: set_err = 1;
            endcase
        end
        if (cap_at == cyc) m_dout = cap_val;
        if (fin_at == cyc) begin
            if (fin_done) inc = 1;
            else set_err = 1;
        end
        sz = mq.size();
        do_pop = (cyc >= next_pop) && (sz > 0);
        if (do_pop) begin
            cur = mq.pop_front();
            disp_at = cyc + 1;
            case (cur.cmd)
                8'h02: next_pop = cyc + 4;
                8'h03: begin
                    if (cur.lat != 0 && cur.lat <= TMO) begin m = cur.lat; fin_done = 1; end
                    else begin m = TMO; fin_done = 0; end
                    fin_at   = cyc + 1 + m;
                    next_pop = cyc + 2 + m;
                    drv_lat_q.push_back(cur.lat);
                end
                default: next_pop = cyc + 2;
            endcase
        end
        if (frame_valid === 1'b1) begin
            if (sz < DEPTH || do_pop) begin
                f = '{cmd, tile_i, tile_j, op_code, data_in, stim_lat};
                mq.push_back(f);
            end else begin
                set_ovf = 1;
            end
        end
        if (set_err) m_err = 1'b1;
        if (set_ovf) m_ovf = 1'b1;
        if (inc) m_cnt = m_cnt + 4'd1;
    endtask

    initial begin : model
        forever begin
            @(posedge clk);
            cyc++;
            model_edge();
        end
    end

    // Engine responder: answers each launch after its planned latency (0 = never).
    initial begin : eng_watch
        int l;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && eng_start === 1'b1) begin
                l = (drv_lat_q.size() != 0) ? drv_lat_q.pop_front() : 0;
                if (l != 0) done_due = cyc + l;
            end
        end
    end

    initial begin : eng_drive
        forever begin
            @(posedge clk);
            #2;
            if (rst_n !== 1'b1) done_due = -1;
            eng_done = manual_done || (done_due == cyc + 1);
        end
    end

    initial begin : monitor
        exp_t x;
        bit   busy_exp;
        forever begin
            @(negedge clk);
            if (m_valid && m_in_reset) begin
                check("reset_outputs", 64'({data_out, buf_we, buf_addr, buf_wdata, res_re, res_addr,
                      eng_start, eng_tile, eng_op, busy, err, ovf}), 64'd0);
            end else if (m_valid) begin
                if (buf_we !== 1'b0) begin
                    if (wr_q.size() == 0) check("buf_we_extra", 64'(buf_we), 64'd0);
                    else begin
                        x = wr_q.pop_front();
                        check("buf_we_cycle", 64'(cyc), 64'(x.cyc));
                        check("buf_addr", 64'(buf_addr), 64'(x.a));
                        check("buf_wdata", 64'(buf_wdata), 64'(x.b));
                    end
                end
                if (wr_q.size() != 0 && wr_q[0].cyc < cyc) begin
                    x = wr_q.pop_front();
                    check("buf_we_missing_cycle", 64'(cyc), 64'(x.cyc));
                end
                if (res_re !== 1'b0) begin
                    if (rd_q.size() == 0) check("res_re_extra", 64'(res_re), 64'd0);
                    else begin
                        x = rd_q.pop_front();
                        check("res_re_cycle", 64'(cyc), 64'(x.cyc));
                        check("res_addr", 64'(res_addr), 64'(x.a));
                    end
                end
                if (rd_q.size() != 0 && rd_q[0].cyc < cyc) begin
                    x = rd_q.pop_front();
                    check("res_re_missing_cycle", 64'(cyc), 64'(x.cyc));
                end
                if (eng_start !== 1'b0) begin
                    if (st_q.size() == 0) check("eng_start_extra", 64'(eng_start), 64'd0);
                    else begin
                        x = st_q.pop_front();
                        check("eng_start_cycle", 64'(cyc), 64'(x.cyc));
                        check("eng_tile", 64'(eng_tile), 64'(x.a));
                        check("eng_op", 64'(eng_op), 64'(x.b));
                    end
                end
                if (st_q.size() != 0 && st_q[0].cyc < cyc) begin
                    x = st_q.pop_front();
                    check("eng_start_missing_cycle", 64'(cyc), 64'(x.cyc));
                end
                busy_exp = (mq.size() != 0) || (cyc < next_pop - 1);
                check("data_out", 64'(data_out), 64'(m_dout));
                check("err", 64'(err), 64'(m_err));
                check("ovf", 64'(ovf), 64'(m_ovf));
                check("busy", 64'(busy), 64'(busy_exp));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [7:0] c, input logic [2:0] ti, input logic [2:0] tj,
                        input logic [2:0] op, input logic [7:0] d, input int lat);
        frame_valid = 1'b1; cmd = c; tile_i = ti; tile_j = tj; op_code = op; data_in = d;
        stim_lat = lat;
        step(1);
        frame_valid = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        step(n);
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while ((mq.size() != 0 || cyc < next_pop) && n < bound) begin
            step(1);
            n++;
        end
        if (n >= bound) begin
            total++; bad++;
            $display("FAIL idle_wait: still busy after %0d cycles (cycle %0d)", n, cyc);
        end
        step(2);
    endtask

    initial begin : stim
        logic [7:0] c;
        int r, lat;
        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom_range(0, 255));
        mem[6'h19] = 8'h3C;
        step(1);
        do_reset(3);

        send(8'h01, 3'd2, 3'd5, 3'd0, 8'hA5, 0);
        wait_idle(50);
        send(8'h02, 3'd3, 3'd1, 3'd0, 8'h00, 0);
        wait_idle(50);
        check("dir_read_data", 64'(data_out), 64'h3C);
        send(8'h03, 3'd7, 3'd7, 3'd5, 8'h00, 10);
        wait_idle(100);
        send(8'h04, 3'd0, 3'd0, 3'd0, 8'h00, 0);
        wait_idle(50);
        check("dir_status_done", 64'(data_out), 64'h01);

        do_reset(2);
        send(8'h03, 3'd1, 3'd2, 3'd3, 8'h00, 0);
        send(8'h04, 3'd0, 3'd0, 3'd0, 8'h00, 0);
        wait_idle(100);
        check("dir_status_timeout", 64'(data_out), 64'h20);
        check("dir_err_timeout", 64'(err), 64'd1);

        // Reset while the engine is outstanding, then a stray completion.
        send(8'h03, 3'd4, 3'd4, 3'd1, 8'h00, 0);
        step(6);
        do_reset(2);
        manual_done = 1;
        step(1);
        manual_done = 0;
        step(3);
        send(8'h04, 3'd0, 3'd0, 3'd0, 8'h00, 0);
        wait_idle(50);
        check("dir_status_after_reset", 64'(data_out), 64'h00);
        check("dir_err_after_reset", 64'(err), 64'd0);

        // Fill the queue behind a long launch; the fifth frame is dropped.
        send(8'h03, 3'd7, 3'd7, 3'd5, 8'h00, TMO);
        step(2);
        send(8'h01, 3'd1, 3'd1, 3'd0, 8'h11, 0);
        send(8'h7E, 3'd0, 3'd0, 3'd0, 8'h00, 0);
        send(8'h02, 3'd3, 3'd1, 3'd0, 8'h00, 0);
        send(8'h04, 3'd0, 3'd0, 3'd0, 8'h00, 0);
        send(8'h01, 3'd6, 3'd6, 3'd0, 8'h66, 0);
        wait_idle(100);
        check("dir_ovf", 64'(ovf), 64'd1);
        check("dir_err_unknown", 64'(err), 64'd1);

        for (int k = 0; k < 400; k++) begin
            if (k % 100 == 0) do_reset(2);
            r = int'($urandom_range(0, 99));
            if (r < 20) c = 8'h01;
            else if (r < 40) c = 8'h02;
            else if (r < 55) c = 8'h03;
            else if (r < 75) c = 8'h04;
            else if (r < 85) c = 8'h00;
            else c = 8'($urandom_range(5, 255));
            lat = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(2, TMO));
            send(c, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), lat);
            step(int'($urandom_range(0, 4)));
        end
        wait_idle(2000);
        step(4);
        check("wr_left", 64'(wr_q.size()), 64'd0);
        check("rd_left", 64'(rd_q.size()), 64'd0);
        check("start_left", 64'(st_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
